// File: rtl/drive_arbiter.sv
// Drive ownership arbiter: IR manual / camera auto / search / e-stop sequencing,
// with a ramped PWM duty and stop-before-reverse ordering on the applied command.
module drive_arbiter #(
  parameter logic [7:0]  CODE_FWD       = 8'h02,
  parameter logic [7:0]  CODE_REV       = 8'h08,
  parameter logic [7:0]  CODE_LEFT      = 8'h04,
  parameter logic [7:0]  CODE_RIGHT     = 8'h06,
  parameter logic [7:0]  CODE_STOP      = 8'h05,
  parameter logic [7:0]  CODE_AUTO      = 8'h01,
  parameter logic [7:0]  CODE_ESTOP     = 8'h00,
  parameter int unsigned MANUAL_HOLD    = 5_000_000,
  parameter int unsigned LOST_TIMEOUT   = 25_000_000,
  parameter int unsigned SEARCH_TIMEOUT = 100_000_000,
  parameter int unsigned RAMP_DIV       = 50_000,
  parameter int unsigned RAMP_STEP      = 8
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       ir_valid,
  input  logic [7:0] IR_button,
  input  logic [2:0] CAM_direction,
  input  logic       orange_detected,
  input  logic [1:0] speed,
  output logic [2:0] drive_cmd,
  output logic [7:0] duty,
  output logic [2:0] mode,
  output logic       cmd_changed
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MANUAL = 3'd1,
    S_AUTO   = 3'd2,
    S_SEARCH = 3'd3,
    S_ESTOP  = 3'd4
  } state_t;

  localparam logic [2:0] C_STOP  = 3'd0;
  localparam logic [2:0] C_FWD   = 3'd1;
  localparam logic [2:0] C_REV   = 3'd2;
  localparam logic [2:0] C_LEFT  = 3'd3;
  localparam logic [2:0] C_RIGHT = 3'd4;
  localparam logic [8:0] STEP9   = 9'(RAMP_STEP);
  localparam logic [7:0] STEP8   = 8'(RAMP_STEP);

  state_t      state, state_next;
  logic [2:0]  manual_cmd, code_cmd, cam_cmd, req_cmd;
  logic        is_motion, is_estop, is_stop, is_auto, ramp_tick;
  logic [31:0] hold_cnt, lost_cnt, search_cnt, div_cnt;
  logic [7:0]  target, ramp_target, duty_ramped;
  logic [8:0]  duty_up;

  assign is_estop  = ir_valid && (IR_button == CODE_ESTOP);
  assign is_stop   = ir_valid && (IR_button == CODE_STOP);
  assign is_auto   = ir_valid && (IR_button == CODE_AUTO);
  assign ramp_tick = (div_cnt == RAMP_DIV - 1);
  assign mode      = state;

  always_comb begin
    code_cmd  = C_STOP;
    is_motion = 1'b0;
    if (ir_valid) begin
      is_motion = 1'b1;
      if      (IR_button == CODE_FWD)   code_cmd = C_FWD;
      else if (IR_button == CODE_REV)   code_cmd = C_REV;
      else if (IR_button == CODE_LEFT)  code_cmd = C_LEFT;
      else if (IR_button == CODE_RIGHT) code_cmd = C_RIGHT;
      else                              is_motion = 1'b0;
    end
  end

  always_comb begin
    case (CAM_direction)
      3'b001:  cam_cmd = C_LEFT;
      3'b010:  cam_cmd = C_FWD;
      3'b100:  cam_cmd = C_RIGHT;
      default: cam_cmd = C_STOP;
    endcase
  end

  always_comb begin
    case (state)
      S_MANUAL: req_cmd = manual_cmd;
      S_AUTO:   req_cmd = orange_detected ? cam_cmd : C_STOP;
      S_SEARCH: req_cmd = C_LEFT;
      default:  req_cmd = C_STOP;
    endcase
  end

  // E-stop beats every other IR code, which in turn beats camera/timer events.
  always_comb begin
    state_next = state;
    if (is_estop) begin
      state_next = S_ESTOP;
    end else if (state == S_ESTOP) begin
      if (is_stop) state_next = S_IDLE;
    end else if (is_motion) begin
      state_next = S_MANUAL;
    end else if (is_auto) begin
      state_next = S_AUTO;
    end else if (is_stop) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_MANUAL: if (hold_cnt == 32'd1) state_next = S_IDLE;
        S_AUTO:   if (!orange_detected && lost_cnt == 32'd1) state_next = S_SEARCH;
        S_SEARCH: begin
          if (orange_detected)             state_next = S_AUTO;
          else if (search_cnt == 32'd1)    state_next = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // A pending direction change forces the ramp to zero before the command swaps.
  always_comb begin
    target      = (req_cmd == C_STOP) ? 8'd0 : {speed, 6'h3f};
    ramp_target = (drive_cmd != req_cmd) ? 8'd0 : target;
    duty_up     = {1'b0, duty} + STEP9;
    duty_ramped = duty;
    if (duty < ramp_target) begin
      duty_ramped = (duty_up >= {1'b0, ramp_target}) ? ramp_target : duty_up[7:0];
    end else if (duty > ramp_target) begin
      duty_ramped = ({1'b0, duty} <= ({1'b0, ramp_target} + STEP9)) ? ramp_target : duty - STEP8;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state       <= S_IDLE;
      manual_cmd  <= C_STOP;
      hold_cnt    <= '0;
      lost_cnt    <= '0;
      search_cnt  <= '0;
      div_cnt     <= '0;
      drive_cmd   <= C_STOP;
      duty        <= '0;
      cmd_changed <= 1'b0;
    end else begin
      state       <= state_next;
      cmd_changed <= 1'b0;

      if (is_motion && state != S_ESTOP) begin
        manual_cmd <= code_cmd;
        hold_cnt   <= MANUAL_HOLD;
      end else if (state == S_MANUAL && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 32'd1;
      end

      if (state != S_AUTO || orange_detected || is_auto) lost_cnt <= LOST_TIMEOUT;
      else                                               lost_cnt <= lost_cnt - 32'd1;

      if (state != S_SEARCH) search_cnt <= SEARCH_TIMEOUT;
      else                   search_cnt <= search_cnt - 32'd1;

      div_cnt <= ramp_tick ? '0 : div_cnt + 32'd1;

      if (is_estop || state == S_ESTOP) begin
        drive_cmd   <= C_STOP;
        duty        <= '0;
        cmd_changed <= (drive_cmd != C_STOP);
      end else if (drive_cmd != req_cmd && (drive_cmd == C_STOP || duty == '0)) begin
        drive_cmd   <= req_cmd;
        cmd_changed <= 1'b1;
      end else if (ramp_tick) begin
        duty <= duty_ramped;
      end
    end
  end

endmodule

// File: tb/tb_drive_arbiter.sv
// Randomized bench for drive_arbiter: a cycle-level behavioural model pushes the
// expected outputs into a queue; a negedge monitor pops and compares them.
module tb_drive_arbiter;
  localparam int HOLD = 16, LOST = 8, SRCH = 32, DIV = 4, STEP = 16;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic       ir_valid = 1'b0;
  logic [7:0] IR_button = 8'h00;
  logic [2:0] CAM_direction = 3'b000;
  logic       orange_detected = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [2:0] drive_cmd, mode;
  logic [7:0] duty;
  logic       cmd_changed;

  drive_arbiter #(
    .MANUAL_HOLD(HOLD), .LOST_TIMEOUT(LOST), .SEARCH_TIMEOUT(SRCH),
    .RAMP_DIV(DIV), .RAMP_STEP(STEP)
  ) dut (
    .clk_50(clk_50), .reset(reset), .ir_valid(ir_valid), .IR_button(IR_button),
    .CAM_direction(CAM_direction), .orange_detected(orange_detected), .speed(speed),
    .drive_cmd(drive_cmd), .duty(duty), .mode(mode), .cmd_changed(cmd_changed)
  );

  always #5 clk_50 = ~clk_50;

  typedef struct packed {
    logic [2:0] mode;
    logic [2:0] drive;
    logic [7:0] duty;
    logic       chg;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;

  // model: modes 0 idle,1 manual,2 auto,3 search,4 estop; cmds 0 stop,1 fwd,2 rev,3 left,4 right
  int m_mode, m_manual, m_since, m_lost, m_search, m_cyc, m_drive, m_duty, m_chg;

  function automatic int cam_to_cmd(logic [2:0] c);
    if (c == 3'b001) return 3;
    if (c == 3'b010) return 1;
    if (c == 3'b100) return 4;
    return 0;
  endfunction

  function automatic int code_to_cmd(logic [7:0] c);
    case (c)
      8'h02: return 1;
      8'h08: return 2;
      8'h04: return 3;
      8'h06: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic model_edge();
    int req, tgt, mot;
    bit tick, est;
    exp_t e;
    if (reset) begin
      m_mode = 0; m_manual = 0; m_since = 0; m_lost = 0; m_search = 0;
      m_cyc = 0; m_drive = 0; m_duty = 0; m_chg = 0;
    end else begin
      case (m_mode)
        1:       req = m_manual;
        2:       req = orange_detected ? cam_to_cmd(CAM_direction) : 0;
        3:       req = 3;
        default: req = 0;
      endcase
      tick = (m_cyc % DIV) == DIV - 1;
      m_cyc++;
      est = ir_valid && IR_button == 8'h00;
      mot = ir_valid ? code_to_cmd(IR_button) : -1;
      m_chg = 0;
      if (est || m_mode == 4) begin
        m_chg = (m_drive != 0);
        m_drive = 0;
        m_duty = 0;
      end else if (m_drive != req && (m_drive == 0 || m_duty == 0)) begin
        m_drive = req;
        m_chg = 1;
      end else if (tick) begin
        tgt = (m_drive != req || req == 0) ? 0 : (int'(speed) + 1) * 64 - 1;
        if (m_duty < tgt) m_duty = (m_duty + STEP > tgt) ? tgt : m_duty + STEP;
        else              m_duty = (m_duty - STEP < tgt) ? tgt : m_duty - STEP;
      end
      if (est) m_mode = 4;
      else if (m_mode == 4) begin
        if (ir_valid && IR_button == 8'h05) m_mode = 0;
      end else if (mot >= 0) begin
        m_mode = 1; m_manual = mot; m_since = 0;
      end else if (ir_valid && IR_button == 8'h01) begin
        m_mode = 2; m_lost = 0;
      end else if (ir_valid && IR_button == 8'h05) begin
        m_mode = 0;
      end else begin
        case (m_mode)
          1: begin
            m_since++;
            if (m_since >= HOLD) m_mode = 0;
          end
          2: begin
            if (orange_detected) m_lost = 0;
            else begin
              m_lost++;
              if (m_lost == LOST) begin m_mode = 3; m_search = 0; end
            end
          end
          3: begin
            if (orange_detected) begin m_mode = 2; m_lost = 0; end
            else begin
              m_search++;
              if (m_search == SRCH) m_mode = 0;
            end
          end
          default: ;
        endcase
      end
    end
    e.mode = 3'(m_mode); e.drive = 3'(m_drive); e.duty = 8'(m_duty); e.chg = m_chg[0];
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk_50);
    model_edge();
    #1;
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic ir(logic [7:0] code);
    ir_valid = 1'b1;
    IR_button = code;
    cyc();
    ir_valid = 1'b0;
    IR_button = 8'($urandom);
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mode", {5'd0, mode}, {5'd0, e.mode});
        chk("drive_cmd", {5'd0, drive_cmd}, {5'd0, e.drive});
        chk("duty", duty, e.duty);
        chk("cmd_changed", {7'd0, cmd_changed}, {7'd0, e.chg});
      end
    end
  end

  initial begin
    logic [7:0] mcodes[4];
    int tog;
    mcodes = '{8'h02, 8'h08, 8'h04, 8'h06};
    tog = 10;

    reset = 1'b1; run(3); reset = 1'b0;

    speed = 2'd1; ir(8'h02); run(40);
    repeat (4) begin ir(8'h02); run(9); end
    repeat (6) begin ir(8'h08); run(9); end
    run(60);

    ir(8'h01); orange_detected = 1'b1; CAM_direction = 3'b100; run(40);
    orange_detected = 1'b0; run(12);
    orange_detected = 1'b1; run(3);
    orange_detected = 1'b0; run(50);

    speed = 2'd3;
    repeat (8) begin ir(8'h02); run(9); end
    ir(8'h02); run(15);
    ir(8'h00); run(3);
    ir(8'h02); run(3);
    ir(8'h05); run(5);

    speed = 2'd1; ir(8'h01); orange_detected = 1'b1; CAM_direction = 3'b010; run(10);
    reset = 1'b1; cyc(); reset = 1'b0; run(2);
    ir(8'h01); run(40);
    speed = 2'd3; run(40);

    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) tog = $urandom_range(4, 40);
      if ($urandom_range(0, tog - 1) == 0) orange_detected = ~orange_detected;
      if ($urandom_range(0, 15) == 0) CAM_direction = 3'($urandom);
      if ($urandom_range(0, 60) == 0) speed = 2'($urandom);
      reset = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 11) == 0) begin
        int r;
        r = $urandom_range(0, 19);
        ir_valid = 1'b1;
        if (r == 0)       IR_button = 8'h00;
        else if (r <= 2)  IR_button = 8'h01;
        else if (r <= 4)  IR_button = 8'h05;
        else if (r <= 14) IR_button = mcodes[$urandom_range(0, 3)];
        else              IR_button = 8'($urandom);
      end
      cyc();
      ir_valid = 1'b0;
      IR_button = 8'($urandom);
    end
    reset = 1'b0;

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk_50);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
